// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word type plus instruction cache frame, sizing and state types
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = 4;
  localparam int ICACHE_TAG_W = 26;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

  typedef enum logic {IDLE, FETCH} icache_state_t;

endpackage

// File: rtl/icache.sv
// icache: direct-mapped one-word-per-block instruction cache between fetch stage and memory controller
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS   = ICACHE_SETS,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [31:0]       imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  input  logic              flush,
  output logic              iREN,
  output logic [31:0]       iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] data;
  } frame_t;

  frame_t        frames_q [SETS];
  frame_t        frames_d [SETS];
  icache_state_t state_q, state_d;
  word_t         miss_addr_q, miss_addr_d;

  logic [IDX_W-1:0] idx, fill_idx;
  logic [TAG_W-1:0] tag;
  frame_t           frame;

  assign idx      = imemaddr[IDX_W+1:2];
  assign tag      = imemaddr[31:IDX_W+2];
  assign fill_idx = miss_addr_q[IDX_W+1:2];
  assign frame    = frames_q[idx];

  // Datapath-facing hit and fill request; ihit is gated by IDLE so it can never rise during a fill
  always_comb begin
    ihit     = (state_q == IDLE) && imemREN && frame.valid && (frame.tag == tag);
    imemload = ihit ? frame.data : '0;
    iREN     = (state_q == FETCH);
    iaddr    = iREN ? miss_addr_q : '0;
  end

  // Miss capture, fill completion and flush; flush is applied last so it overrides a same-cycle fill
  always_comb begin
    frames_d    = frames_q;
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    if (state_q == IDLE && imemREN && !ihit) begin
      miss_addr_d = imemaddr & ~32'h3;
      state_d     = FETCH;
    end
    if (state_q == FETCH && !iwait) begin
      frames_d[fill_idx] = '{valid: 1'b1, tag: miss_addr_q[31:IDX_W+2], data: iload};
      state_d            = IDLE;
    end
    if (flush)
      for (int i = 0; i < SETS; i++) frames_d[i].valid = 1'b0;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      for (int i = 0; i < SETS; i++) frames_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      frames_q    <= frames_d;
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb_icache: scoreboard bench for icache with a behavioural cache/memory model and a responding memory controller
module tb_icache;
  import cpu_types_pkg::*;

  logic        CLK = 0, nRST = 0, imemREN = 0, flush = 0, iwait = 1;
  logic [31:0] imemaddr = 0, iaddr, iload = 0, imemload;
  logic        ihit, iREN;

  icache dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload)
  );

  always #5 CLK = ~CLK;

  int vectors = 0, miscompares = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // memory contents: overrides for directed words, a fixed hash elsewhere
  logic [31:0] mem_ovr [int];
  function automatic logic [31:0] memval(logic [31:0] a);
    int w = int'(a >> 2);
    return mem_ovr.exists(w) ? mem_ovr[w] : ((a >> 2) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // cache model: which word address each of the 16 frames holds
  bit          mvalid [16];
  logic [31:0] mtag   [16];
  function automatic bit model_hit(logic [31:0] a);
    return mvalid[(a >> 2) % 16] && mtag[(a >> 2) % 16] == (a >> 6);
  endfunction
  task automatic model_fill(logic [31:0] a);
    mvalid[(a >> 2) % 16] = 1;
    mtag[(a >> 2) % 16]   = a >> 6;
  endtask
  task automatic model_flush();
    for (int i = 0; i < 16; i++) mvalid[i] = 0;
  endtask

  // memory controller: wait_cfg<0 picks a random wait count per fill
  int wait_cfg = -1, wait_left = 0, last_wait = 0;
  bit busy = 0;
  always begin
    @(posedge CLK); #1;
    if (iREN) begin
      if (!busy) begin
        busy      = 1;
        wait_left = wait_cfg < 0 ? int'($urandom_range(0, 3)) : wait_cfg;
        last_wait = wait_left;
      end
      if (wait_left > 0) begin
        iwait = 1;
        wait_left--;
        iload = $urandom;
      end else begin
        iwait = 0;
        iload = memval(iaddr);
        busy  = 0;
      end
    end else begin
      iwait = 1;
      busy  = 0;
    end
  end

  // scoreboard
  typedef struct {logic [31:0] data; bit hit;} exp_t;
  exp_t        q[$];
  bit          active = 0, done = 0;
  int          cyc = 0;
  logic [31:0] exp_addr = 0;

  always @(negedge CLK) begin
    exp_t e;
    if (iREN) chk("ihit_in_fetch", 32'(ihit), 0);
    if (!ihit) chk("imemload_no_hit", imemload, 0);
    if (active) begin
      if (iREN) chk("iaddr", iaddr, exp_addr);
      if (ihit) begin
        if (q.size() == 0) chk("queue_empty", 1, 0);
        else begin
          e = q.pop_front();
          chk("imemload", imemload, e.data);
          chk("latency", cyc, e.hit ? 0 : last_wait + 2);
          chk("iren_on_hit", 32'(iREN), 0);
        end
        active = 0;
        done   = 1;
      end else cyc++;
    end
  end

  task automatic request(logic [31:0] a);
    exp_t e;
    e.data = memval(a);
    e.hit  = model_hit(a);
    q.push_back(e);
    imemREN  = 1;
    imemaddr = a;
    exp_addr = a & ~32'h3;
    cyc      = 0;
    done     = 0;
    active   = 1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge CLK); #1;
    end
    if (!done) begin
      chk("timeout", 0, 1);
      active = 0;
      q.delete();
    end
    model_fill(a);
    imemREN = 0;
  endtask

  task automatic wait_hit(string name, logic [31:0] a);
    for (int i = 0; i < 20 && !ihit; i++) @(negedge CLK);
    chk(name, 32'(ihit), 1);
    chk({name, "_data"}, imemload, memval(a));
    @(posedge CLK); #1;
    imemREN = 0;
  endtask

  initial begin
    #2;
    chk("rst_ihit", 32'(ihit), 0);
    chk("rst_imemload", imemload, 0);
    chk("rst_iren", 32'(iREN), 0);
    chk("rst_iaddr", iaddr, 0);
    @(negedge CLK);
    nRST = 1;
    @(posedge CLK); #1;

    // cold miss, then same word at another byte offset, then conflict at index 1
    wait_cfg = 3;
    mem_ovr[1]  = 32'h2001_0005;
    mem_ovr[17] = 32'hAAAA_BBBB;
    request(32'h4);
    request(32'h6);
    request(32'h44);
    request(32'h4);

    // address change mid-fill: the fill finishes to the latched address
    imemREN  = 1;
    imemaddr = 32'h10;
    @(posedge CLK); #1;
    imemaddr = 32'h20;
    repeat (4) begin
      @(negedge CLK);
      chk("t4_iren", 32'(iREN), 1);
      chk("t4_iaddr", iaddr, 32'h10);
    end
    @(negedge CLK);
    chk("t4_idle_iren", 32'(iREN), 0);
    chk("t4_idle_miss", 32'(ihit), 0);
    @(negedge CLK);
    chk("t4_refetch", 32'(iREN), 1);
    chk("t4_refetch_addr", iaddr, 32'h20);
    wait_hit("t4_hit", 32'h20);
    model_fill(32'h10);
    model_fill(32'h20);
    request(32'h10);

    // flush coincident with fill completion
    wait_cfg = 2;
    imemREN  = 1;
    imemaddr = 32'h30;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #2;
      if (iREN && !iwait) break;
    end
    flush = 1;
    @(posedge CLK); #1;
    flush = 0;
    model_flush();
    @(negedge CLK);
    chk("t5_idle", 32'(iREN), 0);
    chk("t5_miss", 32'(ihit), 0);
    @(negedge CLK);
    chk("t5_refetch", 32'(iREN), 1);
    chk("t5_refetch_addr", iaddr, 32'h30);
    wait_hit("t5_hit", 32'h30);
    model_fill(32'h30);
    request(32'h4);
    request(32'h10);

    // asynchronous reset in the middle of a fill
    wait_cfg = 5;
    imemREN  = 1;
    imemaddr = 32'h8;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("t6_fetching", 32'(iREN), 1);
    #2 nRST = 0;
    #1;
    chk("t6_iren", 32'(iREN), 0);
    chk("t6_iaddr", iaddr, 0);
    chk("t6_ihit", 32'(ihit), 0);
    @(negedge CLK);
    nRST    = 1;
    imemREN = 0;
    model_flush();
    @(posedge CLK); #1;
    request(32'h30);
    request(32'h20);

    // random traffic over 4 tags x 16 indexes with occasional flushes
    wait_cfg = -1;
    repeat (200) begin
      if ($urandom_range(0, 15) == 0) begin
        flush = 1;
        @(posedge CLK); #1;
        flush = 0;
        model_flush();
      end
      request((32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 1)) begin
        @(posedge CLK); #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
